// File: rtl/eqrun_sched_pkg.sv
// eqrun_sched_pkg -- shared types and constants for the equal-run scheduler.
//   state_t : scheduler FSM states (IDLE, GRANT, STREAM, REPORT)
//   IDX_W   : width of the requester index / round-robin pointer, sized for
//             the largest supported requester count (8)
package eqrun_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        STREAM,
        REPORT
    } state_t;

    localparam int N_REQ_MAX = 8;
    localparam int IDX_W     = $clog2(N_REQ_MAX);

endpackage

// File: rtl/eqrun_sched_if.sv
// eqrun_sched_if -- requester-side bus of the equal-run scheduler.
//   req      : per-requester request
//   gnt      : one-hot grant
//   s_valid  : per-requester sample valid
//   s_a/s_b  : per-requester sample bits
//   s_last   : per-requester end-of-stream marker
//   s_ready  : per-requester ready (only the granted bit can be high)
//   done     : one-cycle result pulse to the owning requester
//   hit_cnt  : saturating hit count of the last session, held
//   hit_any  : hit_cnt != 0, held
//   timed_out: last session was ended by the idle timeout, held
// Modports: master = requesters/consumer side, slave = scheduler.
interface eqrun_sched_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) ();
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] s_valid;
    logic [N_REQ-1:0] s_a;
    logic [N_REQ-1:0] s_b;
    logic [N_REQ-1:0] s_last;
    logic [N_REQ-1:0] s_ready;
    logic [N_REQ-1:0] done;
    logic [CNT_W-1:0] hit_cnt;
    logic             hit_any;
    logic             timed_out;

    modport master (
        output req, s_valid, s_a, s_b, s_last,
        input  gnt, s_ready, done, hit_cnt, hit_any, timed_out
    );

    modport slave (
        input  req, s_valid, s_a, s_b, s_last,
        output gnt, s_ready, done, hit_cnt, hit_any, timed_out
    );
endinterface

// File: rtl/eqrun_core.sv
// eqrun_core -- shared equal-run detector datapath.
//   clk, reset : clock, async active-high reset
//   clr        : clear run and hit counters (start of session)
//   en         : a sample (a, b) is accepted this cycle
//   a, b       : sample bits
//   cnt        : number of samples whose run of equal pairs reached RUN_LEN,
//                saturating at 2^CNT_W-1
module eqrun_core #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    output logic [CNT_W-1:0] cnt
);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    logic [RUN_W-1:0] run_q, run_d;
    logic             hit;

    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        run_d = run_q;
        if (a != b) begin
            run_d = '0;
        end else if (run_q != RUN_W'(RUN_LEN)) begin
            run_d = run_q + 1'b1;
        end
    end

    // The run counter clamps at RUN_LEN, so every further equal pair is a hit.
    assign hit = (run_d == RUN_W'(RUN_LEN));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q <= '0;
            cnt   <= '0;
        end else if (clr) begin
            run_q <= '0;
            cnt   <= '0;
        end else if (en) begin
            run_q <= run_d;
            if (hit && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/eqrun_sched.sv
// eqrun_sched -- shares one equal-run detector (eqrun_core) among N_REQ
// bit-stream requesters and reports each session's hit count.
//   clk   : clock
//   reset : async active-high reset (aborts any session, no done pulse)
//   bus   : eqrun_sched_if.slave -- req/gnt, per-requester sample stream
//           (s_valid, s_a, s_b, s_last, s_ready) and the held result
//           (done, hit_cnt, hit_any, timed_out)
// Build option: define EQRUN_SCHED_PRIO_EN for fixed priority (lowest
// requesting index wins); otherwise grants rotate round-robin.
module eqrun_sched
    import eqrun_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    eqrun_sched_if.slave bus
);
    localparam int IDLE_W = $clog2(TIMEOUT);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_pick, req_rot;
    logic [IDX_W-1:0] base, pick_idx;
    logic             pick_found;
    logic [IDLE_W-1:0] idle_q;
    logic [CNT_W-1:0] hit_cnt_q, core_cnt, hit_cnt_o;
    logic             timed_out_q;
    logic             g_valid, g_a, g_b, g_last, accept;

    // Granted channel's inputs; masking with the one-hot grant ignores every
    // other channel.
    assign g_valid = |(bus.s_valid & gnt_q);
    assign g_a     = |(bus.s_a & gnt_q);
    assign g_b     = |(bus.s_b & gnt_q);
    assign g_last  = |(bus.s_last & gnt_q);
    assign accept  = (state_q == STREAM) && g_valid;

`ifdef EQRUN_SCHED_PRIO_EN
    assign base = '0;
`else
    logic [IDX_W-1:0] ptr_q, gnt_idx;

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) gnt_idx = IDX_W'(k);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (state_q == REPORT) begin
            ptr_q <= IDX_W'((int'(gnt_idx) + 1) % N_REQ);
        end
    end

    assign base = ptr_q;
`endif

    // Rotate requests so bit 0 is the search start, then take the lowest set
    // bit (the loop runs downward so the smallest offset wins).
    assign req_rot = N_REQ'({bus.req, bus.req} >> base);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(base) + i) % N_REQ);
            end
        end
    end

    assign gnt_pick = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (pick_found) state_d = GRANT;
            GRANT:  state_d = STREAM;
            STREAM: begin
                if (accept && g_last) begin
                    state_d = REPORT;
                end else if (!accept && (idle_q == IDLE_W'(TIMEOUT - 1))) begin
                    state_d = REPORT;
                end
            end
            REPORT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q       <= '0;
            idle_q      <= '0;
            hit_cnt_q   <= '0;
            timed_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE:   if (pick_found) gnt_q <= gnt_pick;
                GRANT:  idle_q <= '0;
                STREAM: begin
                    idle_q <= accept ? '0 : idle_q + 1'b1;
                    if (state_d == REPORT) timed_out_q <= !accept;
                end
                REPORT: begin
                    gnt_q     <= '0;
                    hit_cnt_q <= core_cnt;
                end
                default: ;
            endcase
        end
    end

    eqrun_core #(
        .RUN_LEN(RUN_LEN),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .clr  (state_q == GRANT),
        .en   (accept),
        .a    (g_a),
        .b    (g_b),
        .cnt  (core_cnt)
    );

    // The core count already includes the last sample during REPORT; it is
    // captured on the way out and held until the next REPORT.
    assign hit_cnt_o     = (state_q == REPORT) ? core_cnt : hit_cnt_q;
    assign bus.hit_cnt   = hit_cnt_o;
    assign bus.hit_any   = |hit_cnt_o;
    assign bus.timed_out = timed_out_q;
    assign bus.gnt       = gnt_q;
    assign bus.s_ready   = (state_q == STREAM) ? gnt_q : '0;
    assign bus.done      = (state_q == REPORT) ? gnt_q : '0;
endmodule

// File: tb/tb_eqrun_sched.sv
// tb_eqrun_sched -- self-checking bench for eqrun_sched. Two instances share
// one stimulus: the default configuration and a narrow one (RUN_LEN=1,
// CNT_W=3) whose counter saturates quickly. Expected results come from a
// sliding-window hit model and a scan-order arbitration model.
module tb_eqrun_sched;
    localparam int N    = 4;
    localparam int RL   = 4;
    localparam int CW   = 8;
    localparam int TO   = 16;
    localparam int RL_S = 1;
    localparam int CW_S = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req     = '0;
    logic [N-1:0] s_valid = '0;
    logic [N-1:0] s_a     = '0;
    logic [N-1:0] s_b     = '0;
    logic [N-1:0] s_last  = '0;

    eqrun_sched_if #(.N_REQ(N), .CNT_W(CW))   bus   ();
    eqrun_sched_if #(.N_REQ(N), .CNT_W(CW_S)) bus_s ();

    assign bus.req       = req;
    assign bus.s_valid   = s_valid;
    assign bus.s_a       = s_a;
    assign bus.s_b       = s_b;
    assign bus.s_last    = s_last;
    assign bus_s.req     = req;
    assign bus_s.s_valid = s_valid;
    assign bus_s.s_a     = s_a;
    assign bus_s.s_b     = s_b;
    assign bus_s.s_last  = s_last;

    eqrun_sched #(.N_REQ(N), .RUN_LEN(RL), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    eqrun_sched #(.N_REQ(N), .RUN_LEN(RL_S), .CNT_W(CW_S), .TIMEOUT(TO)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int rr_ptr   = 0;
    bit sa [0:511];
    bit sb [0:511];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A sample is a hit when it and the RUN_LEN-1 samples before it are all
    // equal pairs; the reported count saturates at 2^cw-1.
    function automatic int model_hits(input int n, input int rl, input int cw);
        int h = 0;
        int lim = (1 << cw) - 1;
        for (int k = 0; k < n; k++) begin
            bit ok = (k + 1 >= rl);
            for (int j = k - rl + 1; j <= k; j++) begin
                if (j >= 0 && sa[j] != sb[j]) ok = 0;
            end
            if (ok) h++;
        end
        return (h > lim) ? lim : h;
    endfunction

    function automatic int model_pick(input logic [N-1:0] mask);
        int w = 0;
`ifdef EQRUN_SCHED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) if (mask[i]) w = i;
`else
        for (int off = N - 1; off >= 0; off--) begin
            if (mask[(rr_ptr + off) % N]) w = (rr_ptr + off) % N;
        end
`endif
        return w;
    endfunction

    function automatic void fill_eq(input int n);
        for (int k = 0; k < n; k++) begin
            sa[k] = 1'($urandom);
            sb[k] = sa[k];
        end
    endfunction

    function automatic void fill_rand(input int n);
        for (int k = 0; k < n; k++) begin
            sa[k] = 1'($urandom);
            sb[k] = ($urandom_range(0, 3) != 0) ? sa[k] : !sa[k];
        end
    endfunction

    // Called at a negedge with the scheduler idle; returns at the negedge
    // on which the grant is visible.
    task automatic get_grant(input logic [N-1:0] mask, output int g);
        int waited = 0;
        g   = model_pick(mask);
        req = mask;
        while (waited < 4) begin
            @(negedge clk);
            waited++;
            if (bus.gnt != '0) break;
        end
        check("gnt", bus.gnt, 1 << g);
        check("gnt_s", bus_s.gnt, 1 << g);
        check("gnt_latency", waited, 1);
        check("ready_in_grant", bus.s_ready, 0);
    endtask

    // Streams n samples on channel g with random valid gaps, noise on the
    // other channels and random req[g] drops; returns at the negedge after
    // the last accept.
    task automatic stream(input int g, input int n, input bit with_last);
        int acc = 0, gaps = 0, budget = 0;
        bit pres, rdy, first = 1'b1;
        while (acc < n && budget < 4 * n + 20) begin
            pres    = (gaps >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
            s_valid = N'($urandom);
            s_a     = N'($urandom);
            s_b     = N'($urandom);
            s_last  = N'($urandom);
            s_valid[g] = pres;
            s_a[g]     = sa[acc];
            s_b[g]     = sb[acc];
            s_last[g]  = with_last && (acc == n - 1);
            if ($urandom_range(0, 3) == 0) req[g] = 1'b0;
            rdy = bus.s_ready[g];
            @(negedge clk);
            budget++;
            if (pres && rdy) begin
                acc++;
                gaps = 0;
            end else begin
                gaps++;
            end
            if (first) begin
                first = 1'b0;
                if (acc < n || !with_last) check("ready_in_stream", bus.s_ready, 1 << g);
            end
        end
        if (acc < n) check("stream_budget", acc, n);
        s_valid = '0;
        s_last  = '0;
        s_a     = '0;
        s_b     = '0;
    endtask

    task automatic serve(input logic [N-1:0] mask, input int n, input bit tmo);
        int g, waited, exp_h, exp_s, exp_wait;
        get_grant(mask, g);
        stream(g, n, !tmo);
        if (tmo) begin
            exp_wait = (n == 0) ? TO + 1 : TO;
            waited   = 0;
            while (bus.done == '0 && waited < TO + 4) begin
                s_valid    = N'($urandom);
                s_valid[g] = 1'b0;
                s_last     = N'($urandom);
                @(negedge clk);
                waited++;
            end
            s_valid = '0;
            s_last  = '0;
            check("timeout_latency", waited, exp_wait);
        end
        exp_h = model_hits(n, RL, CW);
        exp_s = model_hits(n, RL_S, CW_S);
        check("done", bus.done, 1 << g);
        check("done_s", bus_s.done, 1 << g);
        check("hit_cnt", bus.hit_cnt, exp_h);
        check("hit_any", bus.hit_any, exp_h != 0);
        check("timed_out", bus.timed_out, tmo);
        check("hit_cnt_s", bus_s.hit_cnt, exp_s);
        check("hit_any_s", bus_s.hit_any, exp_s != 0);
        rr_ptr = (g + 1) % N;
        req    = '0;
        @(negedge clk);
        check("done_clear", bus.done, 0);
        check("gnt_clear", bus.gnt, 0);
        check("hit_cnt_hold", bus.hit_cnt, exp_h);
        check("timed_out_hold", bus.timed_out, tmo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g, n;
        bit seen;
        logic [N-1:0] mask;

        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_ready", bus.s_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_hit_cnt", bus.hit_cnt, 0);
        check("rst_hit_any", bus.hit_any, 0);
        check("rst_timed_out", bus.timed_out, 0);
        reset = 1'b0;
        @(negedge clk);

        // Six equal pairs ending with last.
        fill_eq(6);
        serve(4'b0001, 6, 1'b0);

        // eq,eq,eq,neq,eq,eq,eq,eq(last).
        for (int k = 0; k < 8; k++) begin
            sa[k] = 1'($urandom);
            sb[k] = (k == 3) ? !sa[k] : sa[k];
        end
        serve(4'b0001, 8, 1'b0);

        // Reset in the middle of a stream after five samples.
        fill_eq(5);
        get_grant(4'b0100, g);
        stream(g, 5, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("abort_gnt", bus.gnt, 0);
        check("abort_ready", bus.s_ready, 0);
        check("abort_done", bus.done, 0);
        check("abort_hit_cnt", bus.hit_cnt, 0);
        check("abort_hit_any", bus.hit_any, 0);
        check("abort_timed_out", bus.timed_out, 0);
        check("abort_hit_cnt_s", bus_s.hit_cnt, 0);
        rr_ptr = 0;
        req    = '0;
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (TO + 4) begin
            @(negedge clk);
            if (bus.done != '0 || bus_s.done != '0) seen = 1'b1;
        end
        check("no_done_after_abort", seen, 0);

        // Arbitration order from pointer 0.
        fill_rand(5);
        serve(4'b0101, 5, 1'b0);
        fill_rand(7);
        serve(4'b0101, 7, 1'b0);
        fill_rand(4);
        serve(4'b0011, 4, 1'b0);

        // Silent stream ends by timeout.
        serve(4'b0010, 0, 1'b1);

        // Saturation: narrow counter at 20 samples, wide counter at 300.
        fill_eq(20);
        serve(N'(1) << $urandom_range(0, N - 1), 20, 1'b0);
        fill_eq(300);
        serve(N'(1) << $urandom_range(0, N - 1), 300, 1'b0);

        // Random sessions.
        repeat (30) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            n    = $urandom_range(0, 12);
            fill_rand(n);
            serve(mask, n, (n == 0) || ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
